gate_sweep_checker: RTL

//  Self-test stage wrapped around uni_gates. Drives i_in1/i_in2 through all four input vectors.

---
 rtl/gate_sweep_if.sv | 35 +++
 rtl/gate_sweep_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_if.sv
// Handshake and gate-array signals of the gate sweep self-test stage.
// The master modport is the checker; the slave modport is the controller plus the gate array.
interface gate_sweep_if #(
  parameter int CNT_W = 8
);
  logic             i_start;
  logic             i_abort;
  logic             o_in1;
  logic             o_in2;
  logic             i_not_g;
  logic             i_or_g;
  logic             i_and_g;
  logic             i_nor_g;
  logic             i_nand_g;
  logic             i_xor_g;
  logic             i_xnor_g;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic [6:0]       o_err_mask;
  logic [CNT_W-1:0] o_err_cnt;
  logic [1:0]       o_last_vec;

  modport master (
    input  i_start, i_abort,
    input  i_not_g, i_or_g, i_and_g, i_nor_g, i_nand_g, i_xor_g, i_xnor_g,
    output o_in1, o_in2, o_busy, o_done, o_pass, o_err_mask, o_err_cnt, o_last_vec
  );

  modport slave (
    output i_start, i_abort,
    output i_not_g, i_or_g, i_and_g, i_nor_g, i_nand_g, i_xor_g, i_xnor_g,
    input  o_in1, o_in2, o_busy, o_done, o_pass, o_err_mask, o_err_cnt, o_last_vec
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Self-test stage that sweeps the four input vectors of a 2-input gate array and
// checks the seven gate results against their truth tables.
module gate_sweep_checker #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input logic          i_clk,
  input logic          i_rst_n,
  gate_sweep_if.master sweep
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int SUM_W = ((CNT_W > 4) ? CNT_W : 4) + 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [SET_W-1:0] settle_r, settle_s;
  logic [1:0]       vec_r, vec_s;
  logic [6:0]       mask_r, mask_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             pass_r, pass_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;
  logic             in1_r, in1_s;
  logic             in2_r, in2_s;
  logic             drive_s;
  logic [6:0]       obs_s, mis_s;

  // Truth table ordered {xnor,xor,nand,nor,and,or,not} for vector {in1,in2}
  function automatic logic [6:0] expected_fn(input logic [1:0] v);
    logic a, b;
    a = v[1];
    b = v[0];
    return {~(a ^ b), a ^ b, ~(a & b), ~(a | b), a & b, a | b, ~a};
  endfunction

  function automatic logic [3:0] popcount7(input logic [6:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 7; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // The sum is formed one bit wider than either operand so overflow is visible, then clamped
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [3:0] n);
    logic [SUM_W-1:0] s;
    s = SUM_W'(c) + SUM_W'(n);
    if (s > SUM_W'(CNT_MAX)) begin
      return CNT_MAX;
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  assign obs_s = {sweep.i_xnor_g, sweep.i_xor_g, sweep.i_nand_g, sweep.i_nor_g,
                  sweep.i_and_g, sweep.i_or_g, sweep.i_not_g};
  assign mis_s = expected_fn(vec_r) ^ obs_s;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, sweep bookkeeping and next values of the registered outputs
  always_comb begin
    state_s  = state_r;
    settle_s = settle_r;
    vec_s    = vec_r;
    mask_s   = mask_r;
    cnt_s    = cnt_r;
    pass_s   = pass_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sweep.i_start && !sweep.i_abort) begin
          state_s  = APPLY;
          settle_s = SETTLE_LOAD;
          vec_s    = 2'd0;
          mask_s   = 7'd0;
          cnt_s    = {CNT_W{1'b0}};
          pass_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      APPLY: begin
        if (sweep.i_abort) begin
          state_s = IDLE;
          pass_s  = 1'b0;
        end else if (settle_r == {SET_W{1'b0}}) begin
          state_s = SAMPLE;
        end else begin
          settle_s = settle_r - SET_W'(1);
        end
      end
      SAMPLE: begin
        // An abort here discards the sample so the results freeze at their pre-abort values
        if (sweep.i_abort) begin
          state_s = IDLE;
          pass_s  = 1'b0;
        end else begin
          mask_s = mask_r | mis_s;
          cnt_s  = sat_add(cnt_r, popcount7(mis_s));
          if (vec_r == 2'd3) begin
            state_s = DONE;
            done_s  = 1'b1;
            pass_s  = ~|(mask_r | mis_s);
          end else begin
            state_s  = APPLY;
            vec_s    = vec_r + 2'd1;
            settle_s = SETTLE_LOAD;
          end
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s  = (state_s != IDLE);
    drive_s = (state_s == APPLY) || (state_s == SAMPLE);
    in1_s   = drive_s & vec_s[1];
    in2_s   = drive_s & vec_s[0];
  end

  // Sweep datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      settle_r <= {SET_W{1'b0}};
      vec_r    <= 2'd0;
      mask_r   <= 7'd0;
      cnt_r    <= {CNT_W{1'b0}};
      pass_r   <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      in1_r    <= 1'b0;
      in2_r    <= 1'b0;
    end else begin
      settle_r <= settle_s;
      vec_r    <= vec_s;
      mask_r   <= mask_s;
      cnt_r    <= cnt_s;
      pass_r   <= pass_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
      in1_r    <= in1_s;
      in2_r    <= in2_s;
    end
  end

  assign sweep.o_in1      = in1_r;
  assign sweep.o_in2      = in2_r;
  assign sweep.o_busy     = busy_r;
  assign sweep.o_done     = done_r;
  assign sweep.o_pass     = pass_r;
  assign sweep.o_err_mask = mask_r;
  assign sweep.o_err_cnt  = cnt_r;
  assign sweep.o_last_vec = vec_r;

endmodule
